mii_rx_mac: RTL and testbench

// - MII receive MAC: the receive counterpart of the SimpleMac transmit path.
// - Takes 4-bit MII nibbles from the PHY, strips preamble/SFD, assembles bytes and checks CRC-32.
// - Removes the 4-byte FCS and emits payload bytes as an AXI-stream-like byte stream (no backpressure).
// - Sits between the PHY RX pins and the RX FIFO; clk is the PHY eth_rxclk (25 MHz, 100BASE-TX).

---
 rtl/mii_rx_mac.sv | 155 +++++++++++++++
 tb/tb_mii_rx_mac.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_mac.sv
// mii_rx_mac: MII receive MAC for 100BASE-TX.
// Strips preamble/SFD, assembles nibbles into bytes, checks CRC-32, drops the
// 4-byte FCS and streams the payload out one byte per strobe (no backpressure).
//
// Ports:
//   clk, rstn                     PHY receive clock, async active-low reset
//   eth_rxdv, eth_rxer, eth_rxd   MII receive pins (low nibble of each byte first)
//   rx_tdata/tvalid/tlast/tuser   payload byte stream; tuser=1 marks a bad frame on tlast
//   good_frames, bad_frames       wrapping frame statistics counters
module mii_rx_mac #(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             eth_rxdv,
    input  logic             eth_rxer,
    input  logic [3:0]       eth_rxd,
    output logic [7:0]       rx_tdata,
    output logic             rx_tvalid,
    output logic             rx_tlast,
    output logic             rx_tuser,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames
);
    localparam int unsigned LenW       = $clog2(MAX_LEN + 2);
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
    localparam logic [LenW-1:0] MinLen  = LenW'(MIN_LEN);
    localparam logic [LenW-1:0] MaxLen  = LenW'(MAX_LEN);
    localparam logic [LenW-1:0] LineLen = LenW'(4);  // FCS delay line depth
    localparam logic [LenW-1:0] HoldLen = LenW'(5);  // delay line plus hold register

    typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_t;

    // Reflected CRC-32, one byte LSB first, no final inversion.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
            else                c = c >> 1;
        end
        return c;
    endfunction

    state_t          state;
    logic [31:0]     crc;
    logic [LenW-1:0] byte_cnt;
    logic            nib_odd;
    logic [3:0]      low_nib;
    logic            seen_pre;
    logic            err_seen;
    logic [7:0]      dly [4];
    logic [7:0]      hold;

    logic [7:0] new_byte;
    logic       frame_bad;

    assign new_byte  = {eth_rxd, low_nib};
    // Once the FCS has gone through the CRC, a clean frame leaves the fixed residue.
    assign frame_bad = (crc != CrcResidue) || err_seen || nib_odd || (byte_cnt < MinLen);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= StIdle;
            crc         <= 32'hFFFFFFFF;
            byte_cnt    <= '0;
            nib_odd     <= 1'b0;
            low_nib     <= '0;
            seen_pre    <= 1'b0;
            err_seen    <= 1'b0;
            for (int i = 0; i < 4; i++) dly[i] <= '0;
            hold        <= '0;
            rx_tdata    <= '0;
            rx_tvalid   <= 1'b0;
            rx_tlast    <= 1'b0;
            rx_tuser    <= 1'b0;
            good_frames <= '0;
            bad_frames  <= '0;
        end else begin
            rx_tvalid <= 1'b0;
            rx_tlast  <= 1'b0;
            rx_tuser  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (eth_rxdv) begin
                        state    <= StPreamble;
                        seen_pre <= 1'b0;
                    end
                end
                StPreamble: begin
                    if (!eth_rxdv) begin
                        state <= StIdle;
                    end else if (eth_rxd == 4'h5) begin
                        seen_pre <= 1'b1;
                    end else if (eth_rxd == 4'hD && seen_pre) begin
                        state    <= StData;
                        crc      <= 32'hFFFFFFFF;
                        byte_cnt <= '0;
                        nib_odd  <= 1'b0;
                        err_seen <= 1'b0;
                    end else begin
                        state <= StDrop;
                    end
                end
                StData: begin
                    if (!eth_rxdv) begin
                        state <= StIdle;
                        if (byte_cnt >= HoldLen) begin
                            rx_tdata  <= hold;
                            rx_tvalid <= 1'b1;
                            rx_tlast  <= 1'b1;
                            rx_tuser  <= frame_bad;
                        end
                        if (frame_bad || byte_cnt < HoldLen) bad_frames  <= bad_frames + CNT_W'(1);
                        else                                 good_frames <= good_frames + CNT_W'(1);
                    end else begin
                        if (eth_rxer) err_seen <= 1'b1;
                        nib_odd <= ~nib_odd;
                        if (!nib_odd) begin
                            low_nib <= eth_rxd;
                        end else begin
                            byte_cnt <= byte_cnt + LenW'(1);
                            crc      <= crc_byte(crc, new_byte);
                            dly[0]   <= new_byte;
                            dly[1]   <= dly[0];
                            dly[2]   <= dly[1];
                            dly[3]   <= dly[2];
                            if (byte_cnt >= LineLen) hold <= dly[3];
                            if (byte_cnt == MaxLen) begin
                                // Oversize: close the frame with what is already in hold.
                                if (byte_cnt >= HoldLen) begin
                                    rx_tdata  <= hold;
                                    rx_tvalid <= 1'b1;
                                    rx_tlast  <= 1'b1;
                                    rx_tuser  <= 1'b1;
                                end
                                bad_frames <= bad_frames + CNT_W'(1);
                                state      <= StDrop;
                            end else if (byte_cnt >= HoldLen) begin
                                rx_tdata  <= hold;
                                rx_tvalid <= 1'b1;
                            end
                        end
                    end
                end
                StDrop: begin
                    if (!eth_rxdv) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mii_rx_mac.sv
`timescale 1ns/1ps
module tb_mii_rx_mac;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             eth_rxdv = 1'b0;
    logic             eth_rxer = 1'b0;
    logic [3:0]       eth_rxd = 4'h0;
    logic [7:0]       rx_tdata;
    logic             rx_tvalid;
    logic             rx_tlast;
    logic             rx_tuser;
    logic [CNT_W-1:0] good_frames;
    logic [CNT_W-1:0] bad_frames;

    mii_rx_mac #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .eth_rxdv   (eth_rxdv),
        .eth_rxer   (eth_rxer),
        .eth_rxd    (eth_rxd),
        .rx_tdata   (rx_tdata),
        .rx_tvalid  (rx_tvalid),
        .rx_tlast   (rx_tlast),
        .rx_tuser   (rx_tuser),
        .good_frames(good_frames),
        .bad_frames (bad_frames)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] frm[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_strobes = 0;
    int mdl_good = 0;
    int mdl_bad = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // CRC-32 of frm[0..len-1] as it appears in the FCS field.
    function automatic logic [31:0] fcs_of(input int len);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            b = frm[i];
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // n bytes total; with n >= 4 the last four are a correct FCS.
    task automatic build_frame(input int n, input int seed);
        logic [31:0] f;
        frm.delete();
        if (n < 4) begin
            for (int i = 0; i < n; i++) frm.push_back(8'((i * 37 + seed * 11 + 3) & 255));
        end else begin
            for (int i = 0; i < n - 4; i++) frm.push_back(8'((i * 37 + seed * 11 + 3) & 255));
            f = fcs_of(n - 4);
            frm.push_back(f[7:0]);
            frm.push_back(f[15:8]);
            frm.push_back(f[23:16]);
            frm.push_back(f[31:24]);
        end
    endtask

    // What the receiver must deliver for the frame currently in frm.
    task automatic model_frame(input bit dribble, input bit rxer);
        int n;
        int emit;
        bit fcs_ok;
        bit bad;
        n = frm.size();
        fcs_ok = (n >= 4) && (fcs_of(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
        bad = !fcs_ok || rxer || dribble || (n < MIN_LEN);
        if (n > MAX_LEN) begin
            emit = MAX_LEN - 4;
            bad  = 1'b1;
        end else begin
            emit = (n >= 5) ? n - 4 : 0;
        end
        for (int i = 0; i < emit; i++) exp_q.push_back({frm[i], i == emit - 1, bad});
        if (emit > 0 && !bad) mdl_good++;
        else                  mdl_bad++;
    endtask

    task automatic drive(input logic [3:0] nib, input logic er);
        @(posedge clk);
        #1;
        eth_rxdv = 1'b1;
        eth_rxd  = nib;
        eth_rxer = er;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_tvalid", rx_tvalid, 0);
        check("rst_tlast", rx_tlast, 0);
        check("rst_tuser", rx_tuser, 0);
        check("rst_tdata", rx_tdata, 0);
        check("rst_good", good_frames, 0);
        check("rst_bad", bad_frames, 0);
        exp_q.delete();
        mdl_good = 0;
        mdl_bad  = 0;
        eth_rxdv = 1'b0;
        eth_rxer = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_frame(input bit dribble, input int rxer_byte, input int ifg,
                              input int reset_byte);
        for (int i = 0; i < 15; i++) drive(4'h5, 1'b0);
        drive(4'hD, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == reset_byte) begin
                do_reset();
                return;
            end
            drive(frm[i][3:0], i == rxer_byte);
            drive(frm[i][7:4], i == rxer_byte);
        end
        if (dribble) drive(4'hA, 1'b0);
        @(posedge clk);
        #1;
        eth_rxdv = 1'b0;
        eth_rxer = 1'b0;
        repeat (ifg - 1) @(posedge clk);
    endtask

    task automatic check_counters(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_good"}, good_frames, mdl_good);
        check({tag, "_bad"}, bad_frames, mdl_bad);
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    // Output checker against the model queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_tvalid) begin
                n_strobes++;
                if (exp_q.size() == 0) begin
                    check("extra_strobe", rx_tvalid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", rx_tdata, e.data);
                    check("tlast", rx_tlast, e.last);
                    if (e.last) check("tuser", rx_tuser, e.user);
                end
                if (prev_valid) check("strobe_spacing", rx_tlast, 1);
            end
            prev_valid = rx_tvalid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #5ms;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int s0;
        int g0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tvalid", rx_tvalid, 0);
        check("reset_tlast", rx_tlast, 0);
        check("reset_tdata", rx_tdata, 0);
        check("reset_good", good_frames, 0);
        check("reset_bad", bad_frames, 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: valid 64-byte frame
        build_frame(64, 1);
        model_frame(0, 0);
        s0 = n_strobes;
        send_frame(0, -1, 3, -1);
        check_counters("t1");
        check("t1_strobes", n_strobes - s0, 60);
        check("t1_good_lit", good_frames, 1);

        // 2: one payload bit flipped
        build_frame(64, 1);
        frm[10] = frm[10] ^ 8'h04;
        model_frame(0, 0);
        s0 = n_strobes;
        send_frame(0, -1, 3, -1);
        check_counters("t2");
        check("t2_strobes", n_strobes - s0, 60);
        check("t2_bad_lit", bad_frames, 1);

        // 3: runt with good FCS, then a 3-byte fragment
        build_frame(40, 2);
        model_frame(0, 0);
        s0 = n_strobes;
        send_frame(0, -1, 3, -1);
        check_counters("t3a");
        check("t3a_strobes", n_strobes - s0, 36);
        build_frame(3, 3);
        model_frame(0, 0);
        s0 = n_strobes;
        send_frame(0, -1, 3, -1);
        check_counters("t3b");
        check("t3b_strobes", n_strobes - s0, 0);
        check("t3b_bad_lit", bad_frames, 3);

        // 4: rxer at byte 20, then a dribble nibble
        build_frame(64, 4);
        model_frame(0, 1);
        s0 = n_strobes;
        send_frame(0, 20, 3, -1);
        check_counters("t4a");
        check("t4a_strobes", n_strobes - s0, 60);
        build_frame(64, 5);
        model_frame(1, 0);
        s0 = n_strobes;
        send_frame(1, -1, 3, -1);
        check_counters("t4b");
        check("t4b_strobes", n_strobes - s0, 60);

        // 5: oversize frame
        build_frame(1600, 6);
        model_frame(0, 0);
        s0 = n_strobes;
        send_frame(0, -1, 3, -1);
        check_counters("t5");
        check("t5_strobes", n_strobes - s0, 1514);

        // 6: back-to-back with one idle cycle, then reset mid-frame
        g0 = good_frames;
        s0 = n_strobes;
        build_frame(64, 7);
        model_frame(0, 0);
        send_frame(0, -1, 1, -1);
        build_frame(64, 8);
        model_frame(0, 0);
        send_frame(0, -1, 3, -1);
        check_counters("t6a");
        check("t6a_strobes", n_strobes - s0, 120);
        check("t6a_good_delta", good_frames - g0, 2);

        build_frame(64, 9);
        model_frame(0, 0);
        send_frame(0, -1, 3, 30);
        check_counters("t6b");

        build_frame(64, 10);
        model_frame(0, 0);
        s0 = n_strobes;
        send_frame(0, -1, 3, -1);
        check_counters("t6c");
        check("t6c_strobes", n_strobes - s0, 60);
        check("t6c_good_lit", good_frames, 1);
        check("t6c_bad_lit", bad_frames, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
